nfu_2a_pipe: RTL

NFU_2A_PIPE -- requirements
Module: nfu_2a_pipe

---
 rtl/nfu_pkg.sv | 16 +
 rtl/nfu_2a_pipe_cand_mux.sv | 19 +
 rtl/nfu_2a_pipe.sv | 134 +++++++++++++
 3 files changed

// File: rtl/nfu_pkg.sv
// rtl/nfu_pkg.sv - shared parameter derivation helpers for the NFU pipeline blocks
package nfu_pkg;

  // Never returns less than one, so a select field always has at least one bit.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int cand_count(input int groups, input int out_limit);
    return (groups - 1) * out_limit;
  endfunction

endpackage

// File: rtl/nfu_2a_pipe_cand_mux.sv
// rtl/nfu_2a_pipe_cand_mux.sv - one-of-N candidate select, zero when select is out of range
module nfu_2a_pipe_cand_mux #(
  parameter int BIT_WIDTH = 16,
  parameter int N_CAND    = 15,
  parameter int SEL_WIDTH = 4
) (
  input  logic [N_CAND*BIT_WIDTH-1:0] cand,
  input  logic [SEL_WIDTH-1:0]        sel,
  output logic [BIT_WIDTH-1:0]        data
);

  always_comb begin
    data = '0;
    for (int i = 0; i < N_CAND; i++) begin
      if (sel == SEL_WIDTH'(i)) data = cand[i*BIT_WIDTH +: BIT_WIDTH];
    end
  end

endmodule

// File: rtl/nfu_2a_pipe.sv
// rtl/nfu_2a_pipe.sv - two-stage L1/L2 product routing pipeline with frame-aligned config swap
module nfu_2a_pipe
  import nfu_pkg::*;
#(
  parameter int BIT_WIDTH    = 16,
  parameter int Tn           = 16,
  parameter int G            = 16,
  parameter int OUT_LIMIT    = 1,
  parameter int IN_LIMIT     = 1,
  parameter int L1_SEL_WIDTH = clog2(Tn),
  parameter int L2_SEL_WIDTH = clog2(cand_count(G, OUT_LIMIT) + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [G*Tn*BIT_WIDTH-1:0]            i_nfu1,
  input  logic                                 i_valid,
  output logic                                 o_ready,
  input  logic                                 i_last,
  input  logic                                 i_cfg_valid,
  input  logic [G*OUT_LIMIT*L1_SEL_WIDTH-1:0]  i_cfg_l1_sel,
  input  logic [G*IN_LIMIT*L2_SEL_WIDTH-1:0]   i_cfg_l2_sel,
  output logic                                 o_cfg_pending,
  output logic [G*IN_LIMIT*BIT_WIDTH-1:0]      o_nfu2A,
  output logic                                 o_valid,
  output logic                                 o_last,
  input  logic                                 i_ready
);

  localparam int N_CAND = cand_count(G, OUT_LIMIT);
  localparam int L1_W   = G * OUT_LIMIT * L1_SEL_WIDTH;
  localparam int L2_W   = G * IN_LIMIT * L2_SEL_WIDTH;
  localparam int GRP_W  = OUT_LIMIT * BIT_WIDTH;

  logic [L1_W-1:0]                   act_l1_sel, shd_l1_sel;
  logic [L2_W-1:0]                   act_l2_sel, shd_l2_sel;
  logic                              cfg_pending;
  logic                              s1_valid, s1_last;
  logic [G*GRP_W-1:0]                s1_l1, l1_next;
  logic [L2_W-1:0]                   s1_l2_sel;
  logic [G*IN_LIMIT*BIT_WIDTH-1:0]   mux_out;
  logic                              s2_advance, accept, swap;

  assign s2_advance    = !o_valid || i_ready;
  assign o_ready       = !s1_valid || s2_advance;
  assign accept        = i_valid && o_ready;
  assign swap          = accept && i_last;
  assign o_cfg_pending = cfg_pending;

  // L1: each output picks one product of its own group; out-of-range picks read as zero.
  always_comb begin
    l1_next = '0;
    for (int g = 0; g < G; g++) begin
      for (int j = 0; j < OUT_LIMIT; j++) begin
        for (int t = 0; t < Tn; t++) begin
          if (act_l1_sel[(g*OUT_LIMIT+j)*L1_SEL_WIDTH +: L1_SEL_WIDTH] == L1_SEL_WIDTH'(t))
            l1_next[(g*OUT_LIMIT+j)*BIT_WIDTH +: BIT_WIDTH] = i_nfu1[(g*Tn+t)*BIT_WIDTH +: BIT_WIDTH];
        end
      end
    end
  end

  // L2 candidates for lane g are every other group's L1 block, kept in ascending group order.
  for (genvar g = 0; g < G; g++) begin : g_lane
    logic [N_CAND*BIT_WIDTH-1:0] cand;
    for (genvar c = 0; c < G - 1; c++) begin : g_cand
      localparam int SRC = (c < g) ? c : c + 1;
      assign cand[c*GRP_W +: GRP_W] = s1_l1[SRC*GRP_W +: GRP_W];
    end
    for (genvar k = 0; k < IN_LIMIT; k++) begin : g_mux
      nfu_2a_pipe_cand_mux #(
        .BIT_WIDTH (BIT_WIDTH),
        .N_CAND    (N_CAND),
        .SEL_WIDTH (L2_SEL_WIDTH)
      ) u_mux (
        .cand (cand),
        .sel  (s1_l2_sel[(g*IN_LIMIT+k)*L2_SEL_WIDTH +: L2_SEL_WIDTH]),
        .data (mux_out[(g*IN_LIMIT+k)*BIT_WIDTH +: BIT_WIDTH])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_l1     <= '0;
      s1_l2_sel <= '0;
      o_valid   <= 1'b0;
      o_last    <= 1'b0;
      o_nfu2A   <= '0;
    end else begin
      if (o_ready) s1_valid <= i_valid;
      if (accept) begin
        s1_l1     <= l1_next;
        s1_l2_sel <= act_l2_sel;
        s1_last   <= i_last;
      end
      if (s2_advance) begin
        o_valid <= s1_valid;
        if (s1_valid) begin
          o_nfu2A <= mux_out;
          o_last  <= s1_last;
        end
      end
    end
  end

  // Shadow is kept equal to active after a direct load so a later swap cannot revert it.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_l1_sel  <= '0;
      act_l2_sel  <= '0;
      shd_l1_sel  <= '0;
      shd_l2_sel  <= '0;
      cfg_pending <= 1'b0;
    end else if (swap) begin
      if (i_cfg_valid) begin
        act_l1_sel <= i_cfg_l1_sel;
        act_l2_sel <= i_cfg_l2_sel;
        shd_l1_sel <= i_cfg_l1_sel;
        shd_l2_sel <= i_cfg_l2_sel;
      end else begin
        act_l1_sel <= shd_l1_sel;
        act_l2_sel <= shd_l2_sel;
      end
      cfg_pending <= 1'b0;
    end else if (i_cfg_valid) begin
      shd_l1_sel  <= i_cfg_l1_sel;
      shd_l2_sel  <= i_cfg_l2_sel;
      cfg_pending <= 1'b1;
    end
  end

endmodule
